// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and the receiver state set.
// Used by the receiver and the transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_t;

  // Mode 2'b11 is an alias for "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_majority_sampler.sv
// Two-flop rx synchroniser plus majority-of-3 vote; rxs lags rx by 2 clk.
// No backpressure: samples are taken whenever the FSM strobes samp_strb.
module uart_majority_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic samp_strb,
  output logic rxs,
  output logic bit_val
);

  logic [1:0] sync_q;
  logic [1:0] samp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      samp_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (samp_strb) samp_q <= {samp_q[0], rxs};
    end
  end

  assign rxs = sync_q[1];

  // Third vote is the live rxs on the decision tick.
  assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver; status/strobes registered one clk after the deciding tick.
// No backpressure: a frame ending while full=1 is dropped and flagged with a one-cycle overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 timer_tick,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 full,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_PRE  = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_DEC  = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  rx_state_t            state_q, state_d;
  logic [SW-1:0]        s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_BITS-1:0] sr_q;
  logic [1:0]           pmode_q;
  logic                 two_stop_q, stop_n_q, par_err_q, par_bit_q, fe_q, brk_q;

  logic rxs, bit_val, samp_strb;
  logic dec, wrap, par_en, last_stop, frame_end, end_fe, end_brk;

  uart_majority_sampler u_sampler (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .samp_strb (samp_strb),
    .rxs       (rxs),
    .bit_val   (bit_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RX_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    dec       = timer_tick && (s_q == S_DEC);
    wrap      = timer_tick && (s_q == S_LAST);
    samp_strb = timer_tick && (s_q == S_PRE || s_q == S_MID);
    par_en    = par_enabled(pmode_q);
    last_stop = !two_stop_q || stop_n_q;
    frame_end = (state_q == RX_STOP) && dec && last_stop;
    end_fe    = fe_q | ~bit_val;
    // Break is judged on the first stop bit only.
    end_brk   = brk_q | (~stop_n_q & ~bit_val & ~(|sr_q) & ~par_bit_q);
    state_d   = state_q;
    case (state_q)
      RX_IDLE:     if (!rxs) state_d = RX_START;
      RX_START:    if (dec && bit_val) state_d = RX_IDLE;
                   else if (wrap) state_d = RX_DATA;
      RX_DATA:     if (wrap && n_q == NW'(DATA_BITS)) state_d = par_en ? RX_PARITY : RX_STOP;
      RX_PARITY:   if (wrap) state_d = RX_STOP;
      RX_STOP:     if (frame_end) state_d = end_fe ? RX_BRK_WAIT : RX_IDLE;
      RX_BRK_WAIT: if (rxs) state_d = RX_IDLE;
      default:     state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q           <= '0;
      n_q           <= '0;
      sr_q          <= '0;
      pmode_q       <= PAR_NONE;
      two_stop_q    <= 1'b0;
      stop_n_q      <= 1'b0;
      par_err_q     <= 1'b0;
      par_bit_q     <= 1'b0;
      fe_q          <= 1'b0;
      brk_q         <= 1'b0;
      rx_dout       <= '0;
      rx_done_tick  <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      overrun      <= 1'b0;
      if (state_q == RX_IDLE) begin
        // Per-frame state starts clean; a tick coinciding with the start edge is not counted.
        s_q       <= '0;
        n_q       <= '0;
        stop_n_q  <= 1'b0;
        par_err_q <= 1'b0;
        par_bit_q <= 1'b0;
        fe_q      <= 1'b0;
        brk_q     <= 1'b0;
        if (!rxs) begin
          pmode_q    <= parity_mode;
          two_stop_q <= two_stop;
        end
      end else if (timer_tick) begin
        s_q <= wrap ? '0 : s_q + SW'(1);
        if (dec) begin
          case (state_q)
            RX_DATA: begin
              sr_q <= {bit_val, sr_q[DATA_BITS-1:1]};
              n_q  <= n_q + NW'(1);
            end
            RX_PARITY: begin
              par_bit_q <= bit_val;
              par_err_q <= (pmode_q == PAR_ODD) ? ~^{sr_q, bit_val} : ^{sr_q, bit_val};
            end
            RX_STOP: begin
              stop_n_q <= 1'b1;
              fe_q     <= end_fe;
              brk_q    <= end_brk;
            end
            default: ;
          endcase
        end
        if (frame_end) begin
          rx_dout       <= sr_q;
          parity_error  <= par_err_q;
          framing_error <= end_fe;
          break_detect  <= end_brk;
          rx_done_tick  <= ~full;
          overrun       <= full;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: table vectors, hand sequences and randomized frames against a frame-level model.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx, rx_sm;
  logic       timer_tick;
  logic [1:0] parity_mode;
  logic       two_stop, full;
  logic [7:0] rx_dout;
  logic       rx_done_tick, parity_error, framing_error, break_detect, overrun;
  logic [4:0] dout_sm;
  logic       done_sm, pe_sm, fe_sm, brk_sm, ovr_sm;
  logic [1:0] tdiv = 2'd0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] dout;
    logic pe, fe, brk, done, ovr;
  } res_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       pbit, stop1, stop2, two, full;
    res_t       exp;
  } vec_t;

  res_t       evq[$];
  logic [4:0] evq_sm[$];
  vec_t       tbl[11];

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .timer_tick(timer_tick),
    .parity_mode(parity_mode), .two_stop(two_stop), .full(full),
    .rx_dout(rx_dout), .rx_done_tick(rx_done_tick), .parity_error(parity_error),
    .framing_error(framing_error), .break_detect(break_detect), .overrun(overrun)
  );

  uart_rx_cfg #(.DATA_BITS(5), .OVERSAMPLE(8)) u_small (
    .clk(clk), .reset_n(reset_n), .rx(rx_sm), .timer_tick(timer_tick),
    .parity_mode(2'b00), .two_stop(1'b0), .full(1'b0),
    .rx_dout(dout_sm), .rx_done_tick(done_sm), .parity_error(pe_sm),
    .framing_error(fe_sm), .break_detect(brk_sm), .overrun(ovr_sm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign timer_tick = (tdiv == 2'd0);

  always @(negedge clk) begin
    if (rx_done_tick || overrun)
      evq.push_back({rx_dout, parity_error, framing_error, break_detect, rx_done_tick, overrun});
    if (done_sm || ovr_sm) evq_sm.push_back(dout_sm);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Returns just after the DUT-visible tick edge, so the next drive lands cleanly between ticks.
  task automatic wait_tick();
    do @(negedge clk); while (!timer_tick);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_sm = v;
    else     rx = v;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nb, input int ov,
                            input logic par_en, input logic pbit, input logic s1, input logic s2,
                            input logic two, input bit scramble);
    drive_bit(sel, 1'b0, ov);
    if (scramble) begin
      parity_mode = 2'($urandom);
      two_stop    = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) drive_bit(sel, data[i], ov);
    if (par_en) drive_bit(sel, pbit, ov);
    drive_bit(sel, s1, ov);
    if (two) drive_bit(sel, s2, ov);
  endtask

  // Frame-level expectation straight from the line-format rules.
  function automatic res_t model(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                                 input logic s1, input logic s2, input logic two, input logic fl);
    res_t r;
    int   ones;
    logic pen;
    pen    = (pm == 2'd1) || (pm == 2'd2);
    ones   = $countones(d) + int'(pb);
    r.dout = d;
    r.pe   = pen && ((pm == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0));
    r.fe   = !s1 || (two && !s2);
    r.brk  = (d == 8'h00) && (!pen || !pb) && !s1;
    r.done = !fl;
    r.ovr  = fl;
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                              input logic s1, input logic s2, input logic two, input logic fl,
                              input logic [7:0] ed, input logic epe, input logic efe,
                              input logic ebrk, input logic edn, input logic eov);
    vec_t v;
    v.data = d; v.pmode = pm; v.pbit = pb; v.stop1 = s1; v.stop2 = s2; v.two = two; v.full = fl;
    v.exp  = {ed, epe, efe, ebrk, edn, eov};
    return v;
  endfunction

  task automatic check_frame(input res_t e, input string nm);
    res_t r;
    chk({nm, " events"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      r = evq[0];
      chk({nm, " dout"}, r.dout, e.dout);
      chk({nm, " parity_error"}, r.pe, e.pe);
      chk({nm, " framing_error"}, r.fe, e.fe);
      chk({nm, " break_detect"}, r.brk, e.brk);
      chk({nm, " rx_done_tick"}, r.done, e.done);
      chk({nm, " overrun"}, r.ovr, e.ovr);
    end
    chk({nm, " held dout"}, rx_dout, e.dout);
    chk({nm, " held flags"}, {parity_error, framing_error, break_detect}, {e.pe, e.fe, e.brk});
    evq.delete();
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb, input logic s1,
                           input logic s2, input logic two, input logic fl, input bit scramble);
    parity_mode = pm;
    two_stop    = two;
    full        = fl;
    send_frame(1'b0, {1'b0, d}, 8, 16, (pm == 2'd1) || (pm == 2'd2), pb, s1, s2, two, scramble);
    full = 1'b0;
    drive_bit(1'b0, 1'b1, 32);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, " rx_dout"}, rx_dout, 0);
    chk({nm, " flags"}, {parity_error, framing_error, break_detect}, 0);
    chk({nm, " strobes"}, {rx_done_tick, overrun}, 0);
  endtask

  initial begin
    logic [7:0] d, abandon;
    logic [1:0] pm;
    logic       pb, s1, s2, two, fl;

    tbl[0]  = mk(8'hA5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 0, 0, 1, 0);
    tbl[1]  = mk(8'h0F, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F, 1, 0, 0, 1, 0);
    tbl[2]  = mk(8'h0F, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F, 0, 0, 0, 1, 0);
    tbl[3]  = mk(8'h0F, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F, 0, 0, 0, 1, 0);
    tbl[4]  = mk(8'h0F, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F, 1, 0, 0, 1, 0);
    tbl[5]  = mk(8'h55, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0, 0, 0, 1);
    tbl[6]  = mk(8'hC3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 0, 1, 0, 1, 0);
    tbl[7]  = mk(8'h00, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 0, 1, 0);
    tbl[8]  = mk(8'h00, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1, 1, 1, 0);
    tbl[9]  = mk(8'h00, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1, 0, 1, 0);
    tbl[10] = mk(8'hFF, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1, 0, 0, 1, 0);

    reset_n = 1'b0; rx = 1'b1; rx_sm = 1'b1; full = 1'b0; parity_mode = 2'd0; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    drive_bit(1'b0, 1'b1, 8);

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i].data, tbl[i].pmode, tbl[i].pbit, tbl[i].stop1, tbl[i].stop2,
                tbl[i].two, tbl[i].full, 1'b0);
      check_frame(tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset during data bit 4 of an abandoned frame, then back-to-back frames.
    parity_mode = 2'd0; two_stop = 1'b0;
    abandon = 8'hA5;
    drive_bit(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, abandon[i], 16);
    drive_bit(1'b0, abandon[4], 5);
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_bit(1'b0, 1'b1, 32);
    chk("midreset no strobe", evq.size(), 0);
    send_frame(1'b0, 9'h012, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 9'h034, 8, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 32);
    chk("b2b events", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("b2b first", {evq[0].dout, evq[0].done, evq[0].fe}, {8'h12, 1'b1, 1'b0});
      chk("b2b second", {evq[1].dout, evq[1].done, evq[1].fe}, {8'h34, 1'b1, 1'b0});
    end
    evq.delete();

    // Start glitch: 5 ticks low is rejected.
    drive_bit(1'b0, 1'b0, 5);
    drive_bit(1'b0, 1'b1, 32);
    chk("glitch no strobe", evq.size(), 0);
    run_frame(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame({8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, "after glitch");

    // One-tick dip at s=M inside data bit 0 (a 1) must be outvoted.
    drive_bit(1'b0, 1'b0, 16);
    drive_bit(1'b0, 1'b1, 8);
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 7);
    for (int i = 1; i < 8; i++) drive_bit(1'b0, 1'b0, 16);
    drive_bit(1'b0, 1'b1, 16);
    drive_bit(1'b0, 1'b1, 32);
    check_frame({8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, "majority");

    // Break: line low for 12 bit times.
    drive_bit(1'b0, 1'b0, 12 * 16);
    chk("break events while low", evq.size(), 1);
    drive_bit(1'b0, 1'b1, 32);
    check_frame({8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}, "break");
    run_frame(8'h81, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame({8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, "after break");

    for (int i = 0; i < 16; i++) begin
      d   = 8'($urandom);
      pm  = 2'($urandom_range(0, 3));
      pb  = 1'($urandom_range(0, 1));
      s1  = ($urandom_range(0, 3) != 0);
      s2  = ($urandom_range(0, 3) != 0);
      two = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 3) == 0);
      if (i == 0) d = 8'h00;
      run_frame(d, pm, pb, s1, s2, two, fl, 1'b1);
      check_frame(model(d, pm, pb, s1, s2, two, fl), $sformatf("rand%0d", i));
    end

    send_frame(1'b1, 9'h015, 5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1, 16);
    chk("small events", evq_sm.size(), 1);
    if (evq_sm.size() >= 1) chk("small dout", evq_sm[0], 5'h15);
    chk("small flags", {pe_sm, fe_sm, brk_sm, ovr_sm}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, oversampling UART receiver and the successor to the existing fixed-format receiver in the serial RX path. It sits between the asynchronous `rx` pin and the receive FIFO, paced by the shared baud-rate `timer_tick`. It adds:
- configurable data width, oversampling ratio, parity mode and stop-bit count;
- input synchronisation and majority-of-3 bit sampling;
- start-glitch rejection;
- framing, break and overrun detection.

## Interface
- `DATA_BITS`, 8, data bits per frame, legal 5..9
- `OVERSAMPLE`, 16, timer ticks per bit, even, legal 8..32
- `clk`  in  1  clock
- `reset_n`  in  1  reset reset_n, asynchronous, active-low; clock clk
- `rx`  in  1  asynchronous serial line, idle high
- `timer_tick`  in  1  one-cycle oversample strobe, OVERSAMPLE per bit period
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none
- `two_stop`  in  1  1 = two stop bits
- `full`  in  1  receive FIFO full
- `rx_dout`  out  DATA_BITS  received word, LSB first on the line
- `rx_done_tick`  out  1  one-cycle FIFO push strobe
- `parity_error`, `framing_error`, `break_detect`  out  1 each  status for the last frame; valid from the `rx_done_tick` / `overrun` cycle, held until the next frame ends
- `overrun`  out  1  one-cycle pulse: frame completed while `full`=1

## Operation
- **Input synchroniser:** `rx` passes through 2 flops, both reset to 1, producing `rxs`. All logic below uses `rxs`.
- **States:** IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- **Tick counter `s`:**
  - Width $clog2(OVERSAMPLE).
  - Cleared on entering START.
  - Incremented on `timer_tick`, wrapping mod OVERSAMPLE; each bit occupies one full wrap.
- **Majority sampling:** with M = OVERSAMPLE/2, `rxs` is sampled on the ticks where s = M-1, M and M+1. The bit value is the majority of the 3 samples, decided on the s = M+1 tick.
- **IDLE:** `rxs`=0 -> START. Also latch `parity_mode` and `two_stop`; later changes to these inputs are ignored until the next frame.
- **START:**
  - Decided bit = 1 -> IDLE (glitch rejected, no outputs).
  - Otherwise, on the s wrap -> DATA.
- **DATA:**
  - Each decided bit shifts into the MSB of the shift register.
  - Bit counter width is $clog2(DATA_BITS+1).
  - After DATA_BITS bits, on the s wrap: -> PARITY if parity is enabled, else -> STOP.
- **PARITY:**
  - Decided bit p.
  - Even mode: error = ^{data,p}.
  - Odd mode: error = ~^{data,p}.
  - On the s wrap -> STOP.
- **STOP:**
  - Every stop bit is decided at s = M+1.
  - framing_error = any decided stop bit is 0.
  - Frame end = the decision tick of the last stop bit.
- **At frame end:**
  - Load `rx_dout` and all status flags.
  - Pulse `rx_done_tick` if `full`=0; otherwise pulse `overrun` and drop the word (`rx_dout` is still updated).
- **Break:** data all zero, parity bit (if enabled) 0, and first stop bit 0 -> break_detect=1 and framing_error=1.
- **Next state after frame end:**
  - No framing error -> IDLE in the same cycle. This permits back-to-back frames with the next start edge detected half a bit early.
  - Framing error -> BRK_WAIT, which holds until `rxs`=1, then -> IDLE. No start detection occurs in BRK_WAIT.

## Timing
- Pin-to-`rxs` latency: 2 clk cycles.
- Output registers: `rx_done_tick`, `overrun` and all status outputs are registered. They assert the clk cycle after the `timer_tick` cycle that decides the last stop bit. The strobes are exactly one cycle wide.
- `full` is sampled in the same cycle as that `timer_tick`.
- Reset values: every output 0, state IDLE, counters 0, shift register 0.
- Reset mid-frame: the frame is abandoned with no strobe, and the next falling edge after release starts a new frame cleanly.
- `timer_tick` absent: all state and counters hold.
- `timer_tick` and a start edge in the same cycle in IDLE: enter START with s=0; that tick is not counted.
- Frame length in ticks: OVERSAMPLE*(1 + DATA_BITS + P + S - 1) + M + 2, where P = 1 if parity is enabled and S = number of stop bits, counted from START entry to the frame-end decision.

## Structure
- **Package `uart_pkg`:**
  - parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD;
  - the rx state enum/localparams;
  - shared with the transmitter.
- **Sub-module `uart_majority_sampler`:**
  - contains the 2-flop synchroniser and the 3-sample majority vote;
  - inputs: `rxs` sample strobes from the FSM;
  - outputs: `rxs` and `bit_val`.
- The FSM, counters, shift register and flag logic stay in `uart_rx_cfg`.

## Test plan
All scenarios use OVERSAMPLE=16 and DATA_BITS=8 unless stated.

1. **8N1 frame:** 8N1 frame 0xA5, `full`=0 -> one `rx_done_tick`, `rx_dout`=0xA5, all flags 0.
2. **Parity:**
   - Even parity, data 0x0F, parity bit 1 -> `rx_done_tick` with `parity_error`=1.
   - Same data with parity bit 0 -> `parity_error`=0.
   - Odd mode, same two frames -> inverse results.
3. **Start glitch and single-sample glitch:**
   - `rx` low for 5 ticks, then high -> no strobe, FSM back in IDLE; a following 0x3C frame is received correctly.
   - A 1-tick low pulse at s=M inside a 1 data bit -> bit still 1.
4. **Break:** `rx` held low for 12 bit times -> `rx_done_tick`, `rx_dout`=0x00, `framing_error`=1, `break_detect`=1. No further frame until `rx` returns high, then 0x81 is received correctly.
5. **Overrun and two stop bits:**
   - `full`=1 at frame end of 0x55 -> `rx_done_tick`=0, `overrun` pulses once, `rx_dout`=0x55.
   - `two_stop`=1 with second stop bit 0 -> `framing_error`=1.
6. **Reset mid-frame and small config:**
   - `reset_n` asserted during data bit 4 -> all outputs 0 immediately, no strobe. After release, back-to-back frames 0x12 and 0x34 -> two strobes with correct data.
   - DATA_BITS=5, OVERSAMPLE=8 build, 0x15 -> correct.
